seg_scan_controller: RTL
========================

# seg_scan_controller

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It shares one `seven_segment_display` decoder across `NUM_DIGITS` digits. Each digit in turn gets a dead-time slot and then a display slot, and the block drives the decoder's 4-bit `number` input together with the active-low digit anodes. It accepts new display values from the processor-side I/O logic over a valid/ready handshake and applies them only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; range 2..8.
- `REFRESH_DIV`, 50000: cycles each digit is lit per frame; minimum 2.
- `BLANK_CYCLES`, 16: dead-time cycles before each digit, with all anodes off; minimum 1.
- `clk` in 1: the single clock. All state is clocked on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_value` is valid.
- `in_ready` out 1: the block can accept a value. It equals `!pending`.
- `in_value` in 4*NUM_DIGITS: nibble k is digit k; digit 0 is the least significant and rightmost.
- `lz_blank` in 1: enables leading-zero blanking. It is sampled every cycle.
- `digit_num` out 4: drives the decoder's `number` input. Values above 9 blank the digit.
- `anode` out NUM_DIGITS: active-low digit enables.
- `digit_idx` out clog2(NUM_DIGITS): index of the digit currently being scanned.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Registers**
  - `disp`: the value being displayed, 4*NUM_DIGITS bits.
  - `buf`: the staged value, 4*NUM_DIGITS bits.
  - `pending`: 1 while `buf` holds a value not yet applied.
  - `state`: BLANK or SHOW.
  - `idx`: current digit.
  - `cnt`: slot counter, clog2(max(REFRESH_DIV, BLANK_CYCLES)) bits.
- **Reset values:** `disp` all 4'hF, `buf` 0, `pending` 0, `state` BLANK, `idx` 0, `cnt` 0, `anode` all 1s, `digit_num` 4'hF, `digit_idx` 0, `frame_done` 0, `in_ready` 1.
- **BLANK state**
  - `cnt` counts 0..BLANK_CYCLES-1.
  - `anode` is all 1s.
  - `digit_num` presents the effective nibble of `idx` so the decoder settles before the digit is lit.
  - When `cnt`=BLANK_CYCLES-1: go to SHOW and set `cnt` to 0.
- **SHOW state**
  - `cnt` counts 0..REFRESH_DIV-1.
  - `anode` = ~(1<<idx).
  - `digit_num` = effective nibble of `idx`.
  - When `cnt`=REFRESH_DIV-1: go to BLANK, set `cnt` to 0, and set `idx` to `idx`+1, wrapping from NUM_DIGITS-1 to 0.
- **Frame boundary:** the transition out of SHOW with `idx`=NUM_DIGITS-1. On that edge:
  - If `pending`=1, then `disp` takes `buf` and `pending` clears.
  - `frame_done` is 1 for the following cycle only.
- **Effective nibble**
  - Normally `disp[4k+3:4k]`.
  - If `lz_blank`=1, k>0, and digits k..NUM_DIGITS-1 of `disp` are all 0, it is 4'hF (blank).
  - Digit 0 is never blanked.
- **Handshake**
  - A value is accepted when `in_valid` && `in_ready` on a rising edge: `buf` takes `in_value` and `pending` is set.
  - While `pending`=1, `in_ready`=0 and `in_valid` is ignored.
  - If acceptance and a frame boundary occur in the same cycle:
    - `disp` takes the old `buf`, and that `buf` was necessarily empty because `in_ready`=1 means `pending`=0, so `disp` is unchanged.
    - The new value goes into `buf` and is applied at the next boundary.
  - `in_valid` held high continuously loads one value per frame.
- **Reset mid-operation:** all registers return to their reset values immediately, asynchronously. Any staged value is discarded.

## Timing
- Slot length is BLANK_CYCLES+REFRESH_DIV cycles. Frame length is NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- After reset deasserts:
  - The first rising edge has `cnt`=0 in BLANK for digit 0.
  - `anode[0]` goes low BLANK_CYCLES edges later.
- All outputs are registered except `in_ready`, which is driven directly from `pending`.
- `anode`, `digit_num` and `digit_idx` change on the same edge as `state`/`idx`.
- Two anodes are never low in the same cycle.
- Every anode is high for at least BLANK_CYCLES cycles between consecutive lit digits.
- Accept-to-display latency: from 1 cycle up to 1 frame plus 1 cycle.

## Test plan
Parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.

1. **Reset:** assert `reset` mid-SHOW.
   - Immediately: `anode`=4'b1111, `digit_num`=4'hF, `in_ready`=1.
   - After release: `anode`=4'b1110 exactly 2 cycles later, lasting 8 cycles.
   - `frame_done` pulses every 40 cycles.
2. **Load:** load 16'h1234 with `lz_blank`=0.
   - `in_ready` drops the cycle after acceptance.
   - At the next `frame_done` cycle, `disp` is updated and `in_ready` returns to 1.
   - Scan order and `digit_num` values: `anode` 1110 → 4, 1101 → 3, 1011 → 2, 0111 → 1.
3. **Back-pressure:** with `pending`=1, drive 16'hAAAA with `in_valid` held high.
   - The value is not taken until `in_ready`=1.
   - Then it is accepted, and it is displayed one frame later.
4. **Leading-zero blanking:** value 16'h0070 with `lz_blank`=1.
   - `digit_num` per digit 0..3: 0, 7, F, F.
   - With `lz_blank`=0: 0, 7, 0, 0.
   - Value 16'h0000 with `lz_blank`=1: 0, F, F, F.
5. **Simultaneous accept at a frame boundary:** accept 16'h5678 in the same cycle as a frame boundary.
   - The display is unchanged for that frame.
   - 16'h5678 appears after the following boundary.
6. **Dead-time checker, 2000 random cycles with random loads:**
   - At most one anode is low in any cycle.
   - At least 2 all-high cycles occur between lit digits.
   - `frame_done` occurs exactly every 40 cycles.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Scan controller for a multi-digit common-anode seven-segment display.
// It double-buffers the display value and swaps it only at frame boundaries.
module seg_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [4*NUM_DIGITS-1:0]       in_value,
   input  logic                          lz_blank,
   output logic [3:0]                    digit_num,
   output logic [NUM_DIGITS-1:0]         anode,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_done
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int MX = (REFRESH_DIV > BLANK_CYCLES) ?
                       REFRESH_DIV : BLANK_CYCLES;
   localparam int CW = $clog2(MX);

   localparam logic [0:0] BLANK = 1'b0;
   localparam logic [0:0] SHOW  = 1'b1;

   localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] RLAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);

   logic [W-1:0]  disp;
   logic [W-1:0]  staged;
   logic          pending;
   logic [0:0]    state;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;

   logic          accept;
   logic          blank_end;
   logic          show_end;
   logic          boundary;
   logic [0:0]    nstate;
   logic [IW-1:0] nidx;
   logic [CW-1:0] ncnt;
   logic [W-1:0]  ndisp;
   logic [NUM_DIGITS-1:0] nanode;

   // Digit k is blanked when it and every digit above it are zero.
   function automatic logic [3:0] eff_nib(
      input logic [W-1:0]  d,
      input logic [IW-1:0] k,
      input logic          lz
   );
      logic upper_zero;
      upper_zero = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j >= int'(k) && d[4*j +: 4] != 4'h0)
            upper_zero = 1'b0;
      end
      if (lz && k != '0 && upper_zero)
         return 4'hF;
      return d[4*int'(k) +: 4];
   endfunction

   assign in_ready  = !pending;
   assign accept    = in_valid && !pending;
   assign blank_end = (state == BLANK) && (cnt == BLAST);
   assign show_end  = (state == SHOW) && (cnt == RLAST);
   assign boundary  = show_end && (idx == ILAST);

   always_comb begin
      nstate = state;
      nidx   = idx;
      ncnt   = cnt + 1'b1;
      ndisp  = disp;
      unique case (1'b1)
         blank_end: begin
            nstate = SHOW;
            ncnt   = '0;
         end
         show_end: begin
            nstate = BLANK;
            ncnt   = '0;
            nidx   = (idx == ILAST) ? '0 : idx + 1'b1;
         end
         default: ;
      endcase
      if (boundary && pending)
         ndisp = staged;
   end

   always_comb begin
      nanode = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (nstate == SHOW && nidx == IW'(i))
            nanode[i] = 1'b0;
      end
   end

   // Outputs are computed from next state so they move with state/idx.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp       <= '1;
         staged     <= '0;
         pending    <= 1'b0;
         state      <= BLANK;
         idx        <= '0;
         cnt        <= '0;
         anode      <= '1;
         digit_num  <= 4'hF;
         digit_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= nstate;
         idx        <= nidx;
         cnt        <= ncnt;
         disp       <= ndisp;
         pending    <= accept | (pending & ~boundary);
         if (accept)
            staged  <= in_value;
         anode      <= nanode;
         digit_num  <= eff_nib(ndisp, nidx, lz_blank);
         digit_idx  <= nidx;
         frame_done <= boundary;
      end
   end

endmodule
